// File: rtl/apb_pkg.sv
// Shared types and defaults for the two-requester APB master.
package apb_pkg;

    localparam int APB_ADDR_W = 8;
    localparam int APB_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    function automatic logic [1:0] onehot2(input logic idx);
        return idx ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/apb_rr_arbiter.sv
// Two-way round-robin grant: on contention the requester not granted last wins.
module apb_rr_arbiter
    import apb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last,
    input  logic       en,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = 2'b00;
        if (en) begin
            if (req == 2'b11) begin
                gnt = onehot2(~last);
            end else begin
                gnt = req;
            end
        end
    end

endmodule

// File: rtl/apb_arb_master.sv
// Arbitrates two command ports onto one APB master (IDLE/SETUP/ACCESS).
// Define APB_TIMEOUT_EN to add an ACCESS watchdog of TIMEOUT cycles.
module apb_arb_master
    import apb_pkg::*;
#(
    parameter int ADDR_W  = APB_ADDR_W,
    parameter int DATA_W  = APB_DATA_W,
    parameter int TIMEOUT = 16
) (
    input  logic                pclk,
    input  logic                rst,
    input  logic [1:0]          req_valid,
    input  logic [1:0]          req_write,
    input  logic [2*ADDR_W-1:0] req_addr,
    input  logic [2*DATA_W-1:0] req_wdata,
    output logic [1:0]          req_ready,
    output logic [1:0]          rsp_valid,
    output logic [DATA_W-1:0]   rsp_rdata,
    output logic                rsp_err,
    output logic                psel,
    output logic                penable,
    output logic                pwrite,
    output logic [ADDR_W-1:0]   paddr,
    output logic [DATA_W-1:0]   pwdata,
    input  logic [DATA_W-1:0]   prdata,
    input  logic                pready,
    input  logic                pslverr,
    output logic                busy
);

    apb_state_e          state_reg, state_next;
    logic                last_reg;
    logic                owner_reg;
    logic                pwrite_reg;
    logic [ADDR_W-1:0]   paddr_reg;
    logic [DATA_W-1:0]   pwdata_reg;
    logic [1:0]          rsp_valid_reg;
    logic [DATA_W-1:0]   rsp_rdata_reg;
    logic                rsp_err_reg;

    logic [1:0]          gnt;
    logic                arb_en;
    logic                accept;
    logic                gnt_idx;
    logic                done;
    logic                timed_out;

    logic [ADDR_W-1:0]   addr_slice  [2];
    logic [DATA_W-1:0]   wdata_slice [2];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_slice
            assign addr_slice[gi]  = req_addr[gi*ADDR_W +: ADDR_W];
            assign wdata_slice[gi] = req_wdata[gi*DATA_W +: DATA_W];
        end
    endgenerate

    // Grants are suppressed during reset so no command is consumed by an aborted cycle.
    assign arb_en = (state_reg == IDLE) && !rst;

    apb_rr_arbiter u_arb (
        .req  (req_valid),
        .last (last_reg),
        .en   (arb_en),
        .gnt  (gnt)
    );

    assign accept    = |gnt;
    assign gnt_idx   = gnt[1];
    assign req_ready = gnt;
    assign done      = (state_reg == ACCESS) && pready;

`ifdef APB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt_reg;

    always_ff @(posedge pclk) begin
        if (rst || state_reg == SETUP) begin
            tmo_cnt_reg <= '0;
        end else if (state_reg == ACCESS) begin
            tmo_cnt_reg <= tmo_cnt_reg + 1'b1;
        end
    end

    assign timed_out = (state_reg == ACCESS) && !pready && (tmo_cnt_reg == CNT_W'(TIMEOUT - 1));
`else
    // TIMEOUT only matters when the watchdog is built in.
    logic unused_timeout;
    assign unused_timeout = ^TIMEOUT;
    assign timed_out      = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = SETUP;
            SETUP:   state_next = ACCESS;
            ACCESS:  if (done || timed_out) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_reg     <= IDLE;
            last_reg      <= 1'b1;
            owner_reg     <= 1'b0;
            pwrite_reg    <= 1'b0;
            paddr_reg     <= '0;
            pwdata_reg    <= '0;
            rsp_valid_reg <= 2'b00;
            rsp_rdata_reg <= '0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            rsp_valid_reg <= 2'b00;
            if (accept) begin
                last_reg   <= gnt_idx;
                owner_reg  <= gnt_idx;
                pwrite_reg <= req_write[gnt_idx];
                paddr_reg  <= addr_slice[gnt_idx];
                pwdata_reg <= wdata_slice[gnt_idx];
            end
            // A timeout reports as an error with no read data.
            if (done || timed_out) begin
                rsp_valid_reg <= onehot2(owner_reg);
                rsp_rdata_reg <= (done && !pwrite_reg) ? prdata : '0;
                rsp_err_reg   <= done ? pslverr : 1'b1;
            end
        end
    end

    assign psel      = (state_reg != IDLE);
    assign penable   = (state_reg == ACCESS);
    assign busy      = (state_reg != IDLE);
    assign pwrite    = pwrite_reg;
    assign paddr     = paddr_reg;
    assign pwdata    = pwdata_reg;
    assign rsp_valid = rsp_valid_reg;
    assign rsp_rdata = rsp_rdata_reg;
    assign rsp_err   = rsp_err_reg;

endmodule
